mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
Multi-cycle sequencer for the MIPS datapath (ALU, register file, data memory, PC, instruction register).
- Fetch/decode/execute/memory/writeback FSM: Opcode/Funct from the IR and Zero/Sign from the ALU drive per-state write enables, mux selects and ALUOp.
- Replaces the single-cycle CU in the multi-cycle top level; the datapath control encodings are unchanged.
- Also counts retired instructions for the debug display.

Parameters:
CNT_W, 32, width of retired-instruction counter InsCount

Ports:
CLK  in  1  system clock; one clock, rising edge
Reset  in  1  reset; synchronous, active-low
Opcode  in  6  IR[31:26], stable from the end of S_IF
Funct  in  6  IR[5:0]
Zero  in  1  ALU result == 0 (valid in S_EXE)
Sign  in  1  ALU result sign bit (valid in S_EXE)
PCWre  out  1  PC load enable
IRWre  out  1  instruction register load enable
RegWre  out  1  register-file write enable
ALUSrcA  out  1  ALU A select: SA for SLL, else register data
ALUSrcB  out  1  ALU B select: immediate for ADDI/LW/SW/ORI
RegDst  out  1  dest select: RT for LW/ADDI/ORI, else RD
DB  out  1  writeback select: DM for LW, else ALU
ExtSel  out  1  zero-extend for ORI, else sign-extend
nRD  out  1  data-memory read strobe, active-low
nWR  out  1  data-memory write strobe, active-low
PCSrc  out  2  next-PC select (NEXT_INS/REL_JMP/ABS_JMP/HALT codes)
ALUOp  out  3  ALU operation code
State  out  3  current FSM state, debug
InsCount  out  CNT_W  instructions retired since reset

Behaviour:
- States and encodings: S_IF=000, S_ID=001, S_EXE=010, S_MEM=011, S_WB=100, S_HALT=101. State register updates on the CLK rising edge.
- Reset:
  - Reset==0 at an edge: State<=S_IF and InsCount<=0.
  - While Reset==0: PCWre=0, IRWre=0, RegWre=0, nRD=1, nWR=1, PCSrc=NEXT_INS, ALUOp=ADD.
  - Reset mid-instruction abandons that instruction; no partial write is issued after the reset edge.
- Transitions:
  - IF->ID always.
  - ID: J->IF; HALT->S_HALT; all others->EXE.
  - EXE: BEQ/BNE/BGTZ->IF; LW/SW->MEM; others->WB.
  - MEM: LW->WB; SW->IF.
  - WB->IF.
  - S_HALT self-loops until reset.
- Unknown opcode: treated as R-type ADD path (IF,ID,EXE,WB).
- Strobes, combinational from State/Opcode and gated by Reset:
  - IRWre=1 only in S_IF.
  - RegWre=1 only in S_WB.
  - nRD=0 only in S_MEM with LW.
  - nWR=0 only in S_MEM with SW.
- PCWre=1 for exactly one cycle, in the last state of each instruction:
  - ID for J;
  - EXE for branches;
  - MEM for SW;
  - WB for R-type/ADDI/ORI/LW.
  - PCWre=0 in S_HALT.
- PCSrc:
  - In EXE for branches: BEQ REL_JMP iff Zero; BNE REL_JMP iff !Zero; BGTZ REL_JMP iff !Sign && !Zero.
  - ABS_JMP in ID for J; HALT in S_HALT.
  - NEXT_INS otherwise.
- Mux selects and ALUOp are decoded from Opcode/Funct in all states, so values are stable across EXE/MEM/WB:
  - ALUOp from Funct for R-type (ADD, SUB, AND, OR, SLL, SLT->CMPS).
  - OR for ORI; SUB for branches; ADD otherwise.
- InsCount increments by 1 on each edge where PCWre==1; wraps modulo 2^CNT_W; never increments in S_HALT.
- Latency in cycles: J=2, branches=3, R/ADDI/ORI/SW=4, LW=5.

Decomposition:
- Constants.v gains the S_* state encodings; existing OP_*, FUNCT_*, ALU_*, PC_*, REG_FROM_*, EXT_*, DB_FROM_* codes are reused unchanged.
- One combinational sub-module, mc_decode, maps Opcode/Funct to ALUSrcA, ALUSrcB, RegDst, DB, ExtSel and ALUOp.
- mc_control_unit holds the FSM, strobe gating, PCSrc and the counter.

Test Plan:
- Reset low for 2 edges, then ADD (Opcode 000000, Funct ADD) -> State sequence 000,001,010,100; RegWre=1 and PCWre=1 only in the 4th cycle; ALUOp=ADD; InsCount=1.
- LW -> 5 states IF,ID,EXE,MEM,WB; nRD=0 only in MEM; DB=DM and RegDst=RT; RegWre=1 in WB only; nWR=1 throughout.
- SW then BEQ with Zero=1 -> SW: nWR=0 in MEM, PCWre in MEM, RegWre never 1. BEQ: PCSrc=REL_JMP and PCWre=1 in EXE; BEQ with Zero=0 gives PCSrc=NEXT_INS; InsCount +2.
- BGTZ with Sign=1,Zero=0 -> NEXT_INS; with Sign=0,Zero=0 -> REL_JMP. J -> 2 cycles, PCSrc=ABS_JMP, PCWre=1 in ID.
- HALT -> enters 101 after ID; PCWre=0, PCSrc=HALT; InsCount frozen for 20 cycles.
- Reset pulsed low during S_MEM of SW -> next state S_IF, nWR=1 from the reset edge, InsCount=0.

Source files
------------

// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU operations, PC-source and datapath mux codes.
// No ports; imported by mc_decode and mc_control_unit.
package mc_control_unit_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_CMPS = 3'b101;

  localparam logic [1:0] PC_NEXT_INS = 2'b00;
  localparam logic [1:0] PC_REL_JMP  = 2'b01;
  localparam logic [1:0] PC_ABS_JMP  = 2'b10;
  localparam logic [1:0] PC_HALT     = 2'b11;

  localparam logic REG_FROM_RT = 1'b0;
  localparam logic REG_FROM_RD = 1'b1;
  localparam logic EXT_ZERO    = 1'b0;
  localparam logic EXT_SIGN    = 1'b1;
  localparam logic DB_FROM_ALU = 1'b0;
  localparam logic DB_FROM_DM  = 1'b1;
  localparam logic SRCA_REG    = 1'b0;
  localparam logic SRCA_SA     = 1'b1;
  localparam logic SRCB_REG    = 1'b0;
  localparam logic SRCB_IMM    = 1'b1;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ);
  endfunction

endpackage

// File: rtl/mc_control_unit_decode.sv
// mc_decode: static instruction decode of Opcode/Funct into datapath mux
// selects and ALUOp; purely combinational, zero latency, no flow control.
// Ports: Opcode/Funct in; ALUSrcA, ALUSrcB, RegDst, DB, ExtSel, ALUOp out.
module mc_decode
  import mc_control_unit_pkg::*;
(
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       RegDst,
  output logic       DB,
  output logic       ExtSel,
  output logic [2:0] ALUOp
);

  always_comb begin
    ALUSrcA = SRCA_REG;
    ALUSrcB = SRCB_REG;
    RegDst  = REG_FROM_RD;
    DB      = DB_FROM_ALU;
    ExtSel  = EXT_SIGN;
    ALUOp   = ALU_ADD;
    case (Opcode)
      OP_RTYPE: begin
        case (Funct)
          FUNCT_SUB: ALUOp = ALU_SUB;
          FUNCT_AND: ALUOp = ALU_AND;
          FUNCT_OR:  ALUOp = ALU_OR;
          FUNCT_SLT: ALUOp = ALU_CMPS;
          FUNCT_SLL: begin
            ALUOp   = ALU_SLL;
            ALUSrcA = SRCA_SA;
          end
          default:   ALUOp = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        ALUSrcB = SRCB_IMM;
        RegDst  = REG_FROM_RT;
      end
      OP_ORI: begin
        ALUSrcB = SRCB_IMM;
        RegDst  = REG_FROM_RT;
        ExtSel  = EXT_ZERO;
        ALUOp   = ALU_OR;
      end
      OP_LW: begin
        ALUSrcB = SRCB_IMM;
        RegDst  = REG_FROM_RT;
        DB      = DB_FROM_DM;
      end
      OP_SW:                   ALUSrcB = SRCB_IMM;
      OP_BEQ, OP_BNE, OP_BGTZ: ALUOp   = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS sequencer: IF/ID/EXE/MEM/WB FSM, strobe gating, PCSrc and
// retired-instruction counter. Latency J=2, branch=3, R/ADDI/ORI/SW=4, LW=5.
// No backpressure; Reset (sync, active-low) forces S_IF and masks all strobes.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             Sign,
  output logic             PCWre,
  output logic             IRWre,
  output logic             RegWre,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             RegDst,
  output logic             DB,
  output logic             ExtSel,
  output logic             nRD,
  output logic             nWR,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUOp,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] InsCount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       dec_aluop;
  logic             br_taken;

  mc_decode u_decode (
    .Opcode  (Opcode),
    .Funct   (Funct),
    .ALUSrcA (ALUSrcA),
    .ALUSrcB (ALUSrcB),
    .RegDst  (RegDst),
    .DB      (DB),
    .ExtSel  (ExtSel),
    .ALUOp   (dec_aluop)
  );

  // BGTZ: strictly positive means neither negative nor zero.
  always_comb begin
    br_taken = 1'b0;
    case (Opcode)
      OP_BEQ:  br_taken = Zero;
      OP_BNE:  br_taken = !Zero;
      OP_BGTZ: br_taken = !Sign && !Zero;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:   state_d = S_ID;
      S_ID: begin
        if (Opcode == OP_J)         state_d = S_IF;
        else if (Opcode == OP_HALT) state_d = S_HALT;
        else                        state_d = S_EXE;
      end
      S_EXE: begin
        if (is_branch(Opcode))                        state_d = S_IF;
        else if (Opcode == OP_LW || Opcode == OP_SW)  state_d = S_MEM;
        else                                          state_d = S_WB;
      end
      S_MEM:  state_d = (Opcode == OP_LW) ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Strobes are combinational so a reset asserted mid-instruction kills any
  // pending write in the same cycle, before the reset edge.
  always_comb begin
    PCWre  = 1'b0;
    IRWre  = 1'b0;
    RegWre = 1'b0;
    nRD    = 1'b1;
    nWR    = 1'b1;
    PCSrc  = PC_NEXT_INS;
    if (Reset) begin
      case (state_q)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          if (Opcode == OP_J) begin
            PCWre = 1'b1;
            PCSrc = PC_ABS_JMP;
          end
        end
        S_EXE: begin
          if (is_branch(Opcode)) begin
            PCWre = 1'b1;
            PCSrc = br_taken ? PC_REL_JMP : PC_NEXT_INS;
          end
        end
        S_MEM: begin
          nRD   = (Opcode != OP_LW);
          nWR   = (Opcode != OP_SW);
          PCWre = (Opcode == OP_SW);
        end
        S_WB: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
        end
        S_HALT: PCSrc = PC_HALT;
        default: ;
      endcase
    end
  end

  assign ALUOp    = Reset ? dec_aluop : ALU_ADD;
  assign State    = state_q;
  assign InsCount = cnt_q;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (PCWre) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: per-cycle expected records are queued
// when an instruction is issued and popped on each falling edge.
module tb_mc_control_unit;
  import mc_control_unit_pkg::*;

  logic        CLK, Reset, Zero, Sign;
  logic [5:0]  Opcode, Funct;
  logic        PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, RegDst, DB, ExtSel, nRD, nWR;
  logic [1:0]  PCSrc;
  logic [2:0]  ALUOp, State;
  logic [31:0] InsCount;

  mc_control_unit #(.CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .Sign(Sign),
    .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .RegDst(RegDst), .DB(DB), .ExtSel(ExtSel), .nRD(nRD), .nWR(nWR), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .State(State), .InsCount(InsCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  st;
    logic        pcwre, irwre, regwre, nrd, nwr;
    logic [1:0]  pcsrc;
    logic [2:0]  aluop;
    logic        asa, asb, rdst, db, ext;
    logic [31:0] cnt;
  } rec_t;

  rec_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cnt_m = 0;
  string       cur = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur, tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_aluop(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE) begin
      case (fn)
        FUNCT_SUB: return ALU_SUB;
        FUNCT_AND: return ALU_AND;
        FUNCT_OR:  return ALU_OR;
        FUNCT_SLL: return ALU_SLL;
        FUNCT_SLT: return ALU_CMPS;
        default:   return ALU_ADD;
      endcase
    end
    if (op == OP_ORI) return ALU_OR;
    if (op == OP_BEQ || op == OP_BNE || op == OP_BGTZ) return ALU_SUB;
    return ALU_ADD;
  endfunction

  function automatic rec_t mk_rec(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                  input logic s, input logic [2:0] st, input logic last,
                                  input logic [31:0] cnt);
    rec_t r;
    logic taken;
    taken = (op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BGTZ && !s && !z);
    r.st     = st;
    r.irwre  = (st == 3'b000);
    r.regwre = (st == 3'b100);
    r.nrd    = !(st == 3'b011 && op == OP_LW);
    r.nwr    = !(st == 3'b011 && op == OP_SW);
    r.pcwre  = last;
    if (st == 3'b101)                                r.pcsrc = 2'b11;
    else if (last && op == OP_J)                     r.pcsrc = 2'b10;
    else if (last && st == 3'b010 && taken)          r.pcsrc = 2'b01;
    else                                             r.pcsrc = 2'b00;
    r.aluop = exp_aluop(op, fn);
    r.asa   = (op == OP_RTYPE && fn == FUNCT_SLL);
    r.asb   = (op == OP_ADDI || op == OP_LW || op == OP_SW || op == OP_ORI);
    r.rdst  = !(op == OP_LW || op == OP_ADDI || op == OP_ORI);
    r.db    = (op == OP_LW);
    r.ext   = (op != OP_ORI);
    r.cnt   = cnt;
    return r;
  endfunction

  // Compare queued records one per cycle, then step just past the next edge.
  task automatic drain();
    rec_t e;
    while (sbq.size() > 0) begin
      @(negedge CLK);
      e = sbq.pop_front();
      check("State",    32'(State),    32'(e.st));
      check("PCWre",    32'(PCWre),    32'(e.pcwre));
      check("IRWre",    32'(IRWre),    32'(e.irwre));
      check("RegWre",   32'(RegWre),   32'(e.regwre));
      check("nRD",      32'(nRD),      32'(e.nrd));
      check("nWR",      32'(nWR),      32'(e.nwr));
      check("PCSrc",    32'(PCSrc),    32'(e.pcsrc));
      check("ALUOp",    32'(ALUOp),    32'(e.aluop));
      check("ALUSrcA",  32'(ALUSrcA),  32'(e.asa));
      check("ALUSrcB",  32'(ALUSrcB),  32'(e.asb));
      check("RegDst",   32'(RegDst),   32'(e.rdst));
      check("DB",       32'(DB),       32'(e.db));
      check("ExtSel",   32'(ExtSel),   32'(e.ext));
      check("InsCount", InsCount,      e.cnt);
    end
    @(posedge CLK);
    #1;
  endtask

  // Issue one instruction; caller is positioned just after the edge entering S_IF.
  task automatic run_ins(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic s);
    logic [2:0] seq[$];
    cur = name;
    Opcode = op; Funct = fn; Zero = z; Sign = s;
    seq = {3'b000, 3'b001};
    if (op == OP_HALT) begin
      for (int i = 0; i < 20; i++) seq.push_back(3'b101);
    end else if (op != OP_J) begin
      seq.push_back(3'b010);
      if (op == OP_LW)       seq = {seq, 3'b011, 3'b100};
      else if (op == OP_SW)  seq.push_back(3'b011);
      else if (!(op == OP_BEQ || op == OP_BNE || op == OP_BGTZ)) seq.push_back(3'b100);
    end
    for (int k = 0; k < seq.size(); k++)
      sbq.push_back(mk_rec(op, fn, z, s, seq[k], (op != OP_HALT) && (k == seq.size() - 1), cnt_m));
    if (op != OP_HALT) cnt_m = cnt_m + 1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0; Opcode = OP_RTYPE; Funct = FUNCT_ADD; Zero = 1'b0; Sign = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    cur = "reset";
    check("State",    32'(State),  32'(3'b000));
    check("InsCount", InsCount,    32'd0);
    check("PCWre",    32'(PCWre),  32'd0);
    check("IRWre",    32'(IRWre),  32'd0);
    check("RegWre",   32'(RegWre), 32'd0);
    check("nRD",      32'(nRD),    32'd1);
    check("nWR",      32'(nWR),    32'd1);
    check("PCSrc",    32'(PCSrc),  32'(PC_NEXT_INS));
    check("ALUOp",    32'(ALUOp),  32'(ALU_ADD));
    Reset = 1'b1;

    run_ins("add",     OP_RTYPE, FUNCT_ADD, 1'b0, 1'b0);
    run_ins("lw",      OP_LW,    6'h00,     1'b0, 1'b0);
    run_ins("sw",      OP_SW,    6'h00,     1'b0, 1'b0);
    run_ins("beq_z1",  OP_BEQ,   6'h00,     1'b1, 1'b0);
    run_ins("beq_z0",  OP_BEQ,   6'h00,     1'b0, 1'b0);
    run_ins("bne_z0",  OP_BNE,   6'h00,     1'b0, 1'b1);
    run_ins("bne_z1",  OP_BNE,   6'h00,     1'b1, 1'b0);
    run_ins("bgtz_s1", OP_BGTZ,  6'h00,     1'b0, 1'b1);
    run_ins("bgtz_s0", OP_BGTZ,  6'h00,     1'b0, 1'b0);
    run_ins("bgtz_z1", OP_BGTZ,  6'h00,     1'b1, 1'b0);
    run_ins("j",       OP_J,     6'h00,     1'b0, 1'b0);
    run_ins("sub",     OP_RTYPE, FUNCT_SUB, 1'b0, 1'b0);
    run_ins("and",     OP_RTYPE, FUNCT_AND, 1'b0, 1'b0);
    run_ins("or",      OP_RTYPE, FUNCT_OR,  1'b0, 1'b0);
    run_ins("sll",     OP_RTYPE, FUNCT_SLL, 1'b0, 1'b0);
    run_ins("slt",     OP_RTYPE, FUNCT_SLT, 1'b0, 1'b0);
    run_ins("addi",    OP_ADDI,  6'h00,     1'b0, 1'b0);
    run_ins("ori",     OP_ORI,   6'h00,     1'b0, 1'b0);
    run_ins("unknown", 6'b110011, 6'h15,    1'b0, 1'b0);

    // SW interrupted by reset while in S_MEM.
    cur = "sw_rst";
    Opcode = OP_SW; Funct = 6'h00; Zero = 1'b0; Sign = 1'b0;
    sbq.push_back(mk_rec(OP_SW, 6'h00, 1'b0, 1'b0, 3'b000, 1'b0, cnt_m));
    sbq.push_back(mk_rec(OP_SW, 6'h00, 1'b0, 1'b0, 3'b001, 1'b0, cnt_m));
    sbq.push_back(mk_rec(OP_SW, 6'h00, 1'b0, 1'b0, 3'b010, 1'b0, cnt_m));
    drain();
    @(negedge CLK);
    check("mem_State", 32'(State), 32'(3'b011));
    check("mem_nWR",   32'(nWR),   32'd0);
    check("mem_PCWre", 32'(PCWre), 32'd1);
    Reset = 1'b0;
    #1;
    check("rst_nWR",   32'(nWR),   32'd1);
    check("rst_PCWre", 32'(PCWre), 32'd0);
    check("rst_nRD",   32'(nRD),   32'd1);
    @(posedge CLK);
    #1;
    check("rst_State",    32'(State),  32'(3'b000));
    check("rst_InsCount", InsCount,    32'd0);
    check("rst_nWR2",     32'(nWR),    32'd1);
    check("rst_IRWre",    32'(IRWre),  32'd0);
    cnt_m = 0;
    Reset = 1'b1;

    run_ins("add2", OP_RTYPE, FUNCT_ADD, 1'b0, 1'b0);
    run_ins("halt", OP_HALT,  6'h00,     1'b0, 1'b0);

    // Only reset leaves S_HALT.
    cur = "halt_exit";
    Reset = 1'b0;
    @(posedge CLK);
    #1;
    check("State",    32'(State), 32'(3'b000));
    check("InsCount", InsCount,   32'd0);
    check("PCSrc",    32'(PCSrc), 32'(PC_NEXT_INS));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
